// File: rtl/core_inst_sequencer.sv
// ----------------------------------------------------------------------------
// core_inst_sequencer
//
// Runs one convolution layer on the core without outside help. For each
// kernel position (kij) it loads the weights from xmem into the PE array,
// streams the activations through, and then drains the core output FIFO into
// the psum SRAM, accumulating onto earlier kernel positions. A single start
// pulse runs the whole layer.
//
// Ports
//   clk          clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse; begins a layer when idle
//   abort        synchronous cancel back to idle (held mode/sel/tile kept)
//   mode_in      0: 2-bit, 1: 4-bit; captured at start
//   sel_in       output bank select; captured at start
//   tile_in      corelet tile enables; captured at start
//   ofifo_valid  core output FIFO has data
//   inst         34-bit core instruction word (registered)
//   mode/sel/tile held copies of the values captured at start
//   busy         high in every state except idle
//   done         one-cycle pulse in the cycle after the last psum write
//   kij_idx      current kernel position
//
// inst bit map
//   [33] acc  [32] CEN_pmem  [31] WEN_pmem  [30:20] A_pmem
//   [19] CEN_xmem  [18] WEN_xmem  [17:7] A_xmem  [6] ofifo_rd  [5:4] 0
//   [3] l0_rd  [2] l0_wr  [1] execute  [0] load
// ----------------------------------------------------------------------------
module core_inst_sequencer #(
    parameter int                 row     = 2,
    parameter int                 col     = 2,
    parameter int                 kij_num = 9,
    parameter int                 nij_num = 36,
    parameter int                 a_width = 11,
    parameter logic [a_width-1:0] w_base  = 11'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mode_in,
    input  logic        sel_in,
    input  logic [1:0]  tile_in,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        mode,
    output logic        sel,
    output logic [1:0]  tile,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    localparam int DRAIN_LEN = row + col;
    localparam int MAX_NC    = (nij_num > col) ? nij_num : col;
    localparam int CNT_MAX   = (MAX_NC > DRAIN_LEN) ? MAX_NC : DRAIN_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int KIJ_W     = 4;

    // Both memories disabled and write-disabled, no core strobes.
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WDRAIN,
        S_GAP,
        S_ACT,
        S_ADRAIN,
        S_OREAD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KIJ_W-1:0]   kij_q, kij_d;
    logic               mode_q, mode_d;
    logic               sel_q, sel_d;
    logic [1:0]         tile_q, tile_d;
    logic [33:0]        inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [a_width-1:0] pmem_addr;
    logic [a_width-1:0] xaddr_w;

    // Next-state and counter logic.
    //
    // The instruction word is registered, so every decision is made at the
    // clock edge that starts the cycle it describes: the word for a cycle is
    // decoded from state_d/cnt_d. In OREAD, cnt_q counts transfers already
    // issued. Handshake with the output FIFO: ofifo_valid is sampled at the
    // edge; when high, the word for the following cycle pops one entry
    // (ofifo_rd=1) and writes it to psum address cnt; when low, the following
    // cycle is a stall carrying the idle word and cnt holds. There is no
    // timeout: the sequencer waits for the FIFO indefinitely.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kij_d     = kij_q;
        mode_d    = mode_q;
        sel_d     = sel_q;
        tile_d    = tile_q;
        xfer      = 1'b0;
        pmem_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WLOAD;
                    cnt_d   = '0;
                    kij_d   = '0;
                    mode_d  = mode_in;
                    sel_d   = sel_in;
                    tile_d  = tile_in;
                end
            end
            S_WLOAD: begin
                if (cnt_q == CNT_W'(col - 1)) begin
                    state_d = S_WDRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WDRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                state_d = S_ACT;
                cnt_d   = '0;
            end
            S_ACT: begin
                if (cnt_q == CNT_W'(nij_num - 1)) begin
                    state_d = S_ADRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    // The first OREAD cycle may already carry transfer 0.
                    state_d = S_OREAD;
                    if (ofifo_valid) begin
                        xfer  = 1'b1;
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OREAD: begin
                if (cnt_q == CNT_W'(nij_num)) begin
                    cnt_d = '0;
                    if (kij_q == KIJ_W'(kij_num - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WLOAD;
                        kij_d   = kij_q + KIJ_W'(1);
                    end
                end else if (ofifo_valid) begin
                    xfer      = 1'b1;
                    pmem_addr = a_width'(cnt_q);
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                kij_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                kij_d   = '0;
            end
        endcase

        // abort overrides everything, including a start seen in the same
        // cycle; the held mode/sel/tile survive.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            kij_d   = '0;
            mode_d  = mode_q;
            sel_d   = sel_q;
            tile_d  = tile_q;
            xfer    = 1'b0;
        end
    end

    // Instruction word for the cycle that begins at the coming edge.
    always_comb begin
        xaddr_w = w_base + a_width'(kij_d) * a_width'(col) + a_width'(cnt_d);
        inst_d  = IDLE_WORD;
        case (state_d)
            S_WLOAD: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = xaddr_w;
                inst_d[2]    = 1'b1;
                inst_d[0]    = 1'b1;
            end
            S_WDRAIN: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_ACT: begin
                inst_d[19]   = 1'b0;
                inst_d[17:7] = a_width'(cnt_d);
                inst_d[3]    = 1'b1;
                inst_d[2]    = 1'b1;
                inst_d[1]    = 1'b1;
            end
            S_ADRAIN: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_OREAD: begin
                if (xfer) begin
                    inst_d[33]    = (kij_d != '0);
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = pmem_addr;
                    inst_d[6]     = 1'b1;
                end
            end
            default: begin
                inst_d = IDLE_WORD;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            mode_q  <= 1'b0;
            sel_q   <= 1'b0;
            tile_q  <= 2'b00;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            tile_q  <= tile_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst    = inst_q;
    assign mode    = mode_q;
    assign sel     = sel_q;
    assign tile    = tile_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = kij_q;

endmodule
